// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  // Register word index, taken from Address[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_OVF     = 1;
  localparam int unsigned STAT_CNT_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } txState_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == 5'(DEPTH));
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO responder: TXDATA/STATUS/BAUD_DIV registers feeding an 8N1 serializer through a TX FIFO.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF0000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Select,
  output logic        tx,
  output logic        TxIdle
);

  txState_t    state, stateNext;
  logic [7:0]  shiftReg, shiftNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [15:0] baudCnt, baudCntNext;
  logic        txReg, txNext;
  logic [15:0] baudDiv;
  logic        overflow;
  logic [15:0] reloadVal;
  logic        cntZero;
  logic        popReq;
  logic        pushReq;
  logic        wrEn;
  logic [1:0]  regIdx;
  logic [7:0]  fifoHead;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [4:0]  fifoCount;
  logic        busy;
  logic        unusedBits;

  assign regIdx     = Address[3:2];
  assign Select     = (Address[31:4] == BASE_ADDR[31:4]) && (regIdx != 2'd3);
  assign wrEn       = MemWrite & Select;
  assign pushReq    = wrEn && (regIdx == REG_TXDATA);
  assign unusedBits = ^{Address[1:0], WriteData[31:16]};

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq),
    .pop   (popReq),
    .din   (WriteData[7:0]),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // A divisor of 0 behaves like 1 so every bit lasts at least one cycle
  assign reloadVal = (baudDiv == '0) ? '0 : baudDiv - 16'd1;
  assign cntZero   = (baudCnt == '0);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    stateNext   = state;
    shiftNext   = shiftReg;
    bitIdxNext  = bitIdx;
    baudCntNext = cntZero ? baudCnt : baudCnt - 16'd1;
    txNext      = txReg;
    popReq      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          popReq      = 1'b1;
          shiftNext   = fifoHead;
          txNext      = 1'b0;
          baudCntNext = reloadVal;
          stateNext   = ST_START;
        end
      end
      ST_START: begin
        if (cntZero) begin
          txNext      = shiftReg[0];
          bitIdxNext  = '0;
          baudCntNext = reloadVal;
          stateNext   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cntZero) begin
          baudCntNext = reloadVal;
          if (bitIdx == 3'd7) begin
            txNext    = 1'b1;
            stateNext = ST_STOP;
          end else begin
            shiftNext  = {1'b0, shiftReg[7:1]};
            txNext     = shiftReg[1];
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cntZero) begin
          if (!fifoEmpty) begin
            popReq      = 1'b1;
            shiftNext   = fifoHead;
            txNext      = 1'b0;
            baudCntNext = reloadVal;
            stateNext   = ST_START;
          end else begin
            stateNext = ST_IDLE;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shiftReg <= '0;
      bitIdx   <= '0;
      baudCnt  <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitIdxNext;
      baudCnt  <= baudCntNext;
      txReg    <= txNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baudDiv  <= BAUD_DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wrEn && (regIdx == REG_BAUD)) baudDiv <= WriteData[15:0];
      if (wrEn && (regIdx == REG_STATUS) && WriteData[STAT_OVF]) overflow <= 1'b0;
      else if (pushReq && fifoFull && !popReq) overflow <= 1'b1;
    end
  end

  always_comb begin
    ReadData = '0;
    if (Select && MemRead) begin
      case (regIdx)
        REG_STATUS: begin
          ReadData[STAT_CNT_LSB +: 4] = fifoCount[3:0];
          ReadData[STAT_OVF]          = overflow;
          ReadData[STAT_BUSY]         = busy;
        end
        REG_BAUD: ReadData[15:0] = baudDiv;
        default:  ReadData = '0;
      endcase
    end
  end

  assign tx     = txReg;
  assign TxIdle = (state == ST_IDLE) && (fifoCount == '0);

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that acts as a responder to the processor's data-memory store/load interface. The processor stores bytes into a TX data register. The block buffers them in a small FIFO and serializes each one on a single output line as 8N1. It sits beside DataMemory on the same address, data and control signals (MemWrite, MemRead), selected by address decode inside the block. Its ReadData is muxed into the load path by the top level whenever Select is high.

Parameters:
BASE_ADDR, 32'hFFFF0000, byte address of register 0; registers are word-aligned at +0, +4, +8.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
BAUD_DIV_RESET, 16'd16, clock cycles per serial bit after reset.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
Address  input  32  full byte address (ALU result)
WriteData  input  32  store data (rt value)
MemWrite  input  1  store strobe
MemRead  input  1  load strobe
ReadData  output  32  load data, combinational; 0 when not selected or MemRead=0
Select  output  1  combinational; high when Address[31:4] matches BASE_ADDR[31:4] and Address[3:2] < 3
tx  output  1  serial line, idles high
TxIdle  output  1  high when FIFO is empty and the FSM is in IDLE

Behaviour:
- Register map:
  - +0 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - +4 STATUS: read {26'b0, count[3:0] (bits5:2 hold count with FIFO_DEPTH≤15; use [5:2]), overflow(bit1), busy(bit0)}. Writing 1 to bit1 clears overflow.
  - +8 BAUD_DIV: R/W, bits[15:0]; upper bits read 0.
  - Address[1:0] ignored.
- Reset (synchronous, active-high):
  - Outputs: tx=1, TxIdle=1. ReadData and Select are combinational and follow the address.
  - State: FIFO empty, overflow=0, baud_div=BAUD_DIV_RESET, FSM=IDLE, bit counter=0.
  - Reset mid-frame aborts the frame; tx=1 from the following edge.
- Push: MemWrite & Select & offset 0.
  - Accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: at the edge, pop head into the shift register, tx<=0, go to START, reload the baud counter with max(baud_div,1)-1.
  - A push arriving at edge N with an empty FIFO gives tx low after edge N+1 (1-cycle latency).
  - START: when the baud counter hits 0, tx<=shift[0], go to DATA, bit index=0, reload.
  - DATA: on each counter expiry, shift right and drive the next bit, LSB first. After bit 7 expires, tx<=1 and go to STOP.
  - STOP: on expiry, go to IDLE.
  - If the FIFO is non-empty at STOP expiry, pop immediately and go to START. Frames are then back-to-back with no idle gap.
- Each bit lasts exactly max(baud_div,1) cycles. A full frame is 10×that.
- BAUD_DIV write mid-frame: the current bit finishes with the old count; the new value applies at the next reload.
- busy = (FSM != IDLE).
- count = FIFO occupancy, 0..FIFO_DEPTH.
- Simultaneous push and pop with the FIFO full: both happen, count is unchanged, overflow is not set.
- MemRead and MemWrite in the same cycle: the read sees pre-edge values.
- Writes to unselected addresses have no effect.

Decomposition:
- Package mmio_uart_pkg:
  - register offset constants (TXDATA=0, STATUS=1, BAUD=2 as word index)
  - STATUS bit positions
  - FSM state enum (2-bit)
- Sub-module uart_tx_fifo: synchronous FIFO parameterized by width (8) and depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - Pointer wrap is modulo FIFO_DEPTH.
- Top mmio_uart_tx: decode, register file, baud counter, FSM.

Test Plan:
- Reset, then read STATUS (Address 0xFFFF0004) -> ReadData=0; read BAUD -> 16; tx=1, TxIdle=1.
- Write BAUD=4, then store 0x55 to 0xFFFF0000 -> tx low 1 cycle after the write edge, then 0,1,0,1,0,1,0,1,0,1 each held 4 cycles (start, bits 10101010, stop); TxIdle rises after 40 cycles.
- BAUD=2; store 0xA1,0x02,0x03,0x04,0x05 within 5 consecutive cycles (FIFO_DEPTH 4, FSM popping 0xA1) -> all 5 accepted, overflow=0; a 6th store while full -> dropped, STATUS bit1=1; write STATUS 0x2 -> bit1=0; output shows 5 contiguous 20-cycle frames with no gap.
- Mid-frame (DATA bit 3), write BAUD=8 from 4 -> bit 3 still lasts 4 cycles, bit 4 onward lasts 8.
- Assert reset during DATA of frame 0x0F with 2 bytes queued -> tx=1 next cycle, count=0, no further frames.
- Store to 0xFFFF000C and to 0x10010000 -> Select=0, no FIFO change, ReadData=0; BAUD=0 -> each bit lasts 1 cycle.
